// File: rtl/cond_pkg.sv
// Shared definitions for the condition/flag unit: condition codes,
// flag positions within the {N,Z,C,V} vector and FSM state encodings.
package cond_pkg;

    localparam int COND_W_DEF = 4;
    localparam int FLAG_W_DEF = 4;

    // ARM condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Flag positions counted from the left of the {N,Z,C,V} vector,
    // so N (index 0) lives in the most significant bit.
    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Output buffer occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Pick one flag out of a 4-bit {N,Z,C,V} vector by its left-based index.
    function automatic logic get_flag(input logic [FLAG_W_DEF-1:0] flags, input int idx);
        return flags[FLAG_W_DEF-1-idx];
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Purely combinational ARM condition evaluator: (flags, cond) -> (pass, undef).
// Shared between this unit and the branch unit.
module cond_eval
    import cond_pkg::*;
#(
    parameter int COND_W = COND_W_DEF,
    parameter int FLAG_W = FLAG_W_DEF
) (
    input  logic [FLAG_W-1:0] flags,
    input  logic [COND_W-1:0] cond,
    output logic              pass,
    output logic              undef
);

    logic n, z, c, v;

    assign n = get_flag(flags, FLAG_N);
    assign z = get_flag(flags, FLAG_Z);
    assign c = get_flag(flags, FLAG_C);
    assign v = get_flag(flags, FLAG_V);

    // Decode the condition field against the flags
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        pass  = 1'b0;
        undef = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: undef = 1'b1;
            default: begin
                pass  = 1'b0;
                undef = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Status register for ALU/MSR flag updates plus a one-entry verdict buffer
// that answers condition requests with a registered pass/undef result.
// Requests see the flags being written in the same cycle (forwarding).
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter int COND_W = COND_W_DEF,
    parameter int FLAG_W = FLAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic              alu_s,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              wr_valid,
    input  logic [FLAG_W-1:0] wr_flags,
    input  logic [FLAG_W-1:0] wr_mask,
    input  logic              cond_valid,
    input  logic [COND_W-1:0] cond,
    output logic              cond_ready,
    output logic              pass_valid,
    output logic              pass,
    output logic              cond_undef,
    input  logic              pass_ready,
    output logic [FLAG_W-1:0] flags_out
);

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    state_e            state_q;
    state_e            state_d;
    logic              accept;
    logic              eval_pass;
    logic              eval_undef;
    logic              pass_q;
    logic              undef_q;

    // Next-flags: a direct write wins over a flag-setting ALU result
    always_comb begin
        flags_d = flags_q;
        if (wr_valid) begin
            flags_d = (flags_q & ~wr_mask) | (wr_flags & wr_mask);
        end else if (alu_valid && alu_s) begin
            flags_d = {alu_n, alu_z, alu_c, alu_v};
        end
    end

    // Evaluate on next-flags so a same-cycle update is visible to the request
    cond_eval #(
        .COND_W (COND_W),
        .FLAG_W (FLAG_W)
    ) u_eval (
        .flags (flags_d),
        .cond  (cond),
        .pass  (eval_pass),
        .undef (eval_undef)
    );

    // Buffer FSM: next state and handshake outputs
    always_comb begin
        state_d    = state_q;
        pass_valid = 1'b0;
        cond_ready = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                cond_ready = rst_n;
                if (cond_valid) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                pass_valid = 1'b1;
                cond_ready = rst_n & pass_ready;
                if (pass_ready && !cond_valid) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    assign accept = cond_valid & cond_ready;

    // Status register, FSM state and held verdict
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            flags_q <= '0;
            state_q <= ST_EMPTY;
            pass_q  <= 1'b0;
            undef_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            state_q <= state_d;
            if (accept) begin
                pass_q  <= eval_pass;
                undef_q <= eval_undef;
            end
        end
    end

    assign pass       = pass_q;
    assign cond_undef = undef_q;
    assign flags_out  = flags_q;

endmodule
